// File: rtl/mem_access_unit.sv
// mem_access_unit: requester side of the data memory port. It accepts one
// load/store at a time, range-checks the effective address, performs a
// single-cycle memory access and returns a response over a valid/ready
// handshake. It also keeps saturating debug counters.
module mem_access_unit #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int OFF_W  = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [DATA_W-1:0] req_base,
    input  logic [OFF_W-1:0]  req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_is_load,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [2:0]        resp_rd,
    output logic              resp_err,
    output logic              MemWEn,
    output logic              MemRedEn,
    output logic [ADDR_W-1:0] eff_address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData,
    output logic [CNT_W-1:0]  load_cnt,
    output logic [CNT_W-1:0]  store_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state, state_nxt;
    logic   accept;

    logic [DATA_W+1:0] base_ext, off_ext, sum;
    logic              sum_err;

    logic              is_store_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        rd_q;

    // Effective address: the sum lives in DATA_W+2 bits so the top bit is the
    // sign and any set bit from ADDR_W up to DATA_W means the word address
    // overflowed the memory depth.
    always_comb begin
        base_ext = {2'b00, req_base};
        off_ext  = {{(DATA_W+2-OFF_W){req_offset[OFF_W-1]}}, req_offset};
        sum      = base_ext + off_ext;
        sum_err  = sum[DATA_W+1] || (sum[DATA_W:ADDR_W] != '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state, handshake and combinational memory-port outputs.
    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        accept      = 1'b0;
        MemWEn      = 1'b0;
        MemRedEn    = 1'b0;
        eff_address = '0;
        WriteData   = '0;
        case (state)
            IDLE: begin
                req_ready = !reset;
                accept    = req_valid && !reset;
                if (req_valid) state_nxt = ACCESS;
            end
            ACCESS: begin
                eff_address = addr_q;
                WriteData   = wdata_q;
                MemWEn      = is_store_q && !err_q && !reset;
                MemRedEn    = !is_store_q && !err_q && !reset;
                state_nxt   = RESP;
            end
            RESP: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, response registers and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_store_q   <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            resp_valid   <= 1'b0;
            resp_is_load <= 1'b0;
            resp_rdata   <= '0;
            resp_rd      <= '0;
            resp_err     <= 1'b0;
            load_cnt     <= '0;
            store_cnt    <= '0;
            err_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_store_q <= req_is_store;
                        wdata_q    <= req_wdata;
                        rd_q       <= req_rd;
                        addr_q     <= sum[ADDR_W-1:0];
                        err_q      <= sum_err;
                    end
                end
                ACCESS: begin
                    resp_valid   <= 1'b1;
                    resp_is_load <= !is_store_q;
                    resp_err     <= err_q;
                    resp_rd      <= rd_q;
                    resp_rdata   <= (!is_store_q && !err_q) ? ReadData : '0;
                    if (err_q) begin
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                    end else if (is_store_q) begin
                        if (store_cnt != '1) store_cnt <= store_cnt + 1'b1;
                    end else begin
                        if (load_cnt != '1) load_cnt <= load_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit
// against a word-level memory/transaction model kept in the bench.
module tb_mem_access_unit;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int OFF_W  = 6;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [DATA_W-1:0] req_base;
    logic [OFF_W-1:0]  req_offset;
    logic [DATA_W-1:0] req_wdata;
    logic [2:0]        req_rd;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_is_load;
    logic [DATA_W-1:0] resp_rdata;
    logic [2:0]        resp_rd;
    logic              resp_err;
    logic              MemWEn;
    logic              MemRedEn;
    logic [ADDR_W-1:0] eff_address;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic [CNT_W-1:0]  load_cnt;
    logic [CNT_W-1:0]  store_cnt;
    logic [CNT_W-1:0]  err_cnt;

    mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_is_load(resp_is_load),
        .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err),
        .MemWEn(MemWEn), .MemRedEn(MemRedEn), .eff_address(eff_address),
        .WriteData(WriteData), .ReadData(ReadData),
        .load_cnt(load_cnt), .store_cnt(store_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Environment memory: synchronous write, combinational read, preloadable.
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic              preload;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;
    always @(posedge clk) begin
        if (preload) mem[pl_addr] <= pl_data;
        else if (MemWEn) mem[eff_address] <= WriteData;
    end
    assign ReadData = mem[eff_address];

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    int exp_ld = 0, exp_st = 0, exp_er = 0;

    int ncmp = 0;
    int nfail = 0;
    int acc_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction, entered and left at a negedge.
    task automatic do_req(input bit st, input int base, input int off,
                          input logic [DATA_W-1:0] wd, input logic [2:0] rd,
                          input int hold, input bit keep);
        int w;
        int s;
        bit e;
        int a;
        logic [DATA_W-1:0] exp_rdata;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_idle", req_ready, 1);

        s = base + off;
        e = (s < 0) || (s > DEPTH - 1);
        a = s & (DEPTH - 1);
        exp_rdata = (!st && !e) ? ref_mem[a] : '0;

        req_valid    = 1'b1;
        req_is_store = st;
        req_base     = base[DATA_W-1:0];
        req_offset   = off[OFF_W-1:0];
        req_wdata    = wd;
        req_rd       = rd;
        @(posedge clk);
        acc_cyc = cyc;
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        if (hold > 0) resp_ready = 1'b0;

        check("acc_wen",   MemWEn, (st && !e) ? 1 : 0);
        check("acc_ren",   MemRedEn, (!st && !e) ? 1 : 0);
        check("acc_addr",  eff_address, a);
        check("acc_wdata", WriteData, wd);
        check("acc_rvalid", resp_valid, 0);
        check("acc_rdy",   req_ready, 0);

        if (e) exp_er++;
        else if (st) begin exp_st++; ref_mem[a] = wd; end
        else exp_ld++;

        @(posedge clk);
        @(negedge clk);
        check("resp_valid",   resp_valid, 1);
        check("resp_is_load", resp_is_load, st ? 0 : 1);
        check("resp_err",     resp_err, e);
        check("resp_rd",      resp_rd, rd);
        check("resp_rdata",   resp_rdata, exp_rdata);
        check("load_cnt",     load_cnt, exp_ld);
        check("store_cnt",    store_cnt, exp_st);
        check("err_cnt",      err_cnt, exp_er);
        check("resp_rdy",     req_ready, 0);
        check("resp_wen",     MemWEn | MemRedEn, 0);

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", resp_valid, 1);
            check("bp_rdata", resp_rdata, exp_rdata);
            check("bp_rd",    resp_rd, rd);
            check("bp_err",   resp_err, e);
            check("bp_rdy",   req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("done_valid", resp_valid, 0);
        check("done_rdy",   req_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_base     = '0;
        req_offset   = '0;
        req_wdata    = '0;
        req_rd       = '0;
        resp_ready   = 1'b1;
        preload      = 1'b1;
        pl_addr      = '0;
        pl_data      = '0;

        // Preload random contents while reset is held.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            pl_addr    = i[ADDR_W-1:0];
            pl_data    = DATA_W'($urandom);
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        preload = 1'b0;
        @(negedge clk);
        check("rst_rvalid", resp_valid, 0);
        check("rst_isload", resp_is_load, 0);
        check("rst_rdata",  resp_rdata, 0);
        check("rst_rd",     resp_rd, 0);
        check("rst_err",    resp_err, 0);
        check("rst_mem",    {MemWEn, MemRedEn, eff_address, WriteData}, 0);
        check("rst_cnt",    {load_cnt, store_cnt} | err_cnt, 0);
        check("rst_rdy",    req_ready, 0);
        reset = 1'b0;
        #1;
        check("rst_rdy_rel", req_ready, 1);
        @(negedge clk);

        // Store then load the same word.
        do_req(1'b1, 'h0010, 3, 16'hBEEF, 3'd0, 0, 1'b0);
        check("mem_013", mem[10'h013], 16'hBEEF);
        do_req(1'b0, 'h0010, 3, 16'h0000, 3'd5, 0, 1'b0);

        // Out-of-range addresses.
        do_req(1'b0, 'h03FF, 1, 16'h0, 3'd1, 0, 1'b0);
        do_req(1'b0, 'h0000, -1, 16'h0, 3'd2, 0, 1'b0);
        do_req(1'b1, 'h0000, -1, 16'h5555, 3'd2, 0, 1'b0);

        // Boundaries.
        do_req(1'b0, 'h0400, -1, 16'h0, 3'd3, 0, 1'b0);
        do_req(1'b0, 'h0005, -32, 16'h0, 3'd4, 0, 1'b0);
        do_req(1'b1, 'hFFFF, 31, 16'h1111, 3'd4, 0, 1'b0);

        // Backpressure.
        do_req(1'b0, 'h0010, 3, 16'h0, 3'd6, 5, 1'b0);

        // Back-to-back stores with req_valid held.
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 'h0100 + i, 0, 16'hA000 + 16'(i), 3'd0, 0, 1'b1);
            if (i > 0) check("b2b_interval", acc_cyc - prev, 3);
            prev = acc_cyc;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) check("b2b_mem", mem['h100 + i], 16'hA000 + 16'(i));

        // Reset during the access cycle of a store.
        do_req(1'b1, 'h0020, 0, 16'h1234, 3'd0, 0, 1'b0);
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_base     = 16'h0020;
        req_offset   = '0;
        req_wdata    = 16'hDEAD;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check("rstacc_wen", MemWEn, 0);
        check("rstacc_rdy", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_ld = 0; exp_st = 0; exp_er = 0;
        #1;
        check("rstacc_rvalid", resp_valid, 0);
        check("rstacc_cnt", {load_cnt, store_cnt} | err_cnt, 0);
        check("rstacc_rdy", req_ready, 1);
        check("rstacc_mem", mem[10'h020], 16'h1234);
        @(posedge clk);
        @(negedge clk);
        check("rstacc_rvalid2", resp_valid, 0);
        do_req(1'b0, 'h0020, 0, 16'h0, 3'd7, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            bit st;
            int base, off, hold;
            st   = 1'($urandom_range(0, 1));
            base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                               : int'($urandom_range(0, 1100));
            off  = int'($urandom_range(0, 63)) - 32;
            hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_req(st, base, off, DATA_W'($urandom), 3'($urandom), hold, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Requester side of the data memory port: accepts load/store requests from the CPU execute stage over a valid/ready handshake.
- Computes and range-checks the effective address, then drives MemWEn/MemRedEn/eff_address/WriteData.
- Captures ReadData and returns a response over a second valid/ready handshake.
- Single outstanding request; also keeps saturating load/store/error counters for debug.

Parameters:
ADDR_W, 10, memory word-address width (depth 2^ADDR_W words)
DATA_W, 16, data word width
OFF_W, 6, signed immediate offset width
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_is_store  in  1  1 = store, 0 = load
req_base  in  DATA_W  unsigned base register value
req_offset  in  OFF_W  signed two's-complement offset
req_wdata  in  DATA_W  store data
req_rd  in  3  destination register tag (loads)
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_is_load  out  1  response belongs to a load
resp_rdata  out  DATA_W  load data (0 for stores/errors)
resp_rd  out  3  echoed tag
resp_err  out  1  effective address out of range
MemWEn  out  1  memory write enable
MemRedEn  out  1  memory read enable
eff_address  out  ADDR_W  memory word address
WriteData  out  DATA_W  memory write data
ReadData  in  DATA_W  combinational memory read data
load_cnt, store_cnt, err_cnt  out  CNT_W each  saturating statistics

Behaviour:
- FSM states IDLE, ACCESS, RESP. Reset -> IDLE.
- Reset values: resp_valid=0, resp_is_load=0, resp_rdata=0, resp_rd=0, resp_err=0, MemWEn=0, MemRedEn=0, eff_address=0, WriteData=0, all counters 0.
- req_ready = (state==IDLE) && !reset, combinational.
- IDLE: on req_valid && req_ready, register is_store, wdata, rd; compute sum = zero-extended req_base + sign-extended req_offset in DATA_W+2 signed bits.
  - err = (sum < 0) || (sum > 2^ADDR_W − 1).
  - Register addr = sum[ADDR_W−1:0] and err; go to ACCESS.
- ACCESS (exactly one cycle), memory outputs combinational from registered request:
  - eff_address = addr and WriteData = wdata; both 0 in every other state.
  - MemWEn = is_store && !err && !reset.
  - MemRedEn = !is_store && !err && !reset.
  - At the ending edge: the memory commits the store; the unit captures resp_rdata = ReadData for an error-free load, else 0.
  - Same edge: set resp_valid=1, resp_is_load=!is_store, resp_err=err, resp_rd=rd.
  - Increment exactly one counter: err_cnt if err, else store_cnt or load_cnt. Counters saturate at all-ones. Go to RESP.
- RESP: hold all resp_* stable while resp_valid && !resp_ready. On resp_ready, clear resp_valid at that edge and go to IDLE.
- Throughput: one request per 3 cycles with resp_ready held high; no request is accepted in the same cycle a response is consumed.
- Latency: request accepted at edge N, memory access during cycle N+1, resp_valid high from edge N+2.
- Error requests never assert MemWEn or MemRedEn; error latency equals normal latency.
- Reset in any state: return to IDLE, outputs to reset values.
  - A store in ACCESS while reset is high is not written (MemWEn gated).
  - An in-flight response is discarded; counters clear.
- Reset has priority over every other event.

Test Plan:
- Store base=0x0010, off=+3, wdata=0xBEEF -> MemWEn=1, eff_address=0x013 for one cycle; resp_valid 2 cycles after accept, resp_err=0, store_cnt=1. Then load same address, rd=5 -> resp_rdata=0xBEEF, resp_rd=5, resp_is_load=1, load_cnt=1.
- Load base=0x03FF off=+1 (sum 0x400) and base=0x0000 off=−1 (0x3F) -> resp_err=1, resp_rdata=0, MemWEn/MemRedEn never high, err_cnt=2.
- Boundary addresses: base=0x0400 off=−1 -> eff_address=0x3FF, no error; base=0x0005 off=−32 -> error.
- Backpressure: hold resp_ready=0 for 5 cycles after a load -> resp_* stable, req_ready=0 throughout; resp_ready=1 -> resp_valid drops next edge, req_ready=1.
- Back-to-back: 4 stores with req_valid and resp_ready held high -> accepts every 3rd cycle, 4 writes at correct addresses, store_cnt=4.
- Reset pulse during ACCESS of a store to 0x020 -> location 0x020 unchanged (verified by a later load), resp_valid never asserted, counters 0, req_ready=1 the cycle after reset deasserts.
